hazard_controller: RTL

- Central hazard/sequencing controller for the 5-stage RISC-V pipeline.
- Drives stall, flush and freeze enables for the F/D, D/E, E/M and M/W pipeline registers.
- Selects operand forwarding for the Execute-stage ALU.
- Handles post-reset pipeline scrubbing, load-use bubbles, taken-branch/jump redirects, and multi-cycle data-memory waits with a timeout watchdog.

---
 rtl/hazard_pkg.sv | 8 +
 rtl/hazard_controller_if.sv | 18 +
 rtl/hazard_controller_forward_unit.sv | 17 +
 rtl/hazard_controller.sv | 105 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state, forwarding select and result-source constants for the hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {INIT, RUN, MEMWAIT, HALT} state_t;
    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline-side register ids/requests in, stall/flush/forward controls out.
interface hazard_controller_if;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, DMemReq_M, DMemReady;
    logic       StallF, StallD, FlushD, FlushE, FreezeEMW, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
        output RegWriteM, RegWriteW, PCSrcE, DMemReq_M, DMemReady,
        input  StallF, StallD, FlushD, FlushE, FreezeEMW, MemTimeout, ForwardAE, ForwardBE
    );
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
        input  RegWriteM, RegWriteW, PCSrcE, DMemReq_M, DMemReady,
        output StallF, StallD, FlushD, FlushE, FreezeEMW, MemTimeout, ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_controller_forward_unit.sv
// forward_unit: combinational ALU operand bypass select for one Execute source register (M beats W).
module forward_unit
    import hazard_pkg::*;
(
    input  logic       i_en,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);
    logic w_hit_m, w_hit_w;
    assign w_hit_m = i_reg_write_m && i_rd_m != '0 && i_rd_m == i_rs;
    assign w_hit_w = i_reg_write_w && i_rd_w != '0 && i_rd_w == i_rs;
    assign o_fwd   = !i_en ? FWD_RF : w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/freeze sequencing and forwarding for the 5-stage pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int RESET_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT        = 16
)(
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        PerfStallCycles,
    output logic [31:0]        PerfFlushCount,
    output logic [31:0]        PerfMemWaitCycles
`endif
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           r_state, w_next;
    logic [3:0]       r_init_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_busy, w_lw_stall;

    assign w_mem_busy = hz.DMemReq_M && !hz.DMemReady;
    assign w_lw_stall = hz.ResultSrcE == RESULT_SRC_LOAD && hz.RdE != '0 &&
                        (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    assign hz.MemTimeout = r_state == HALT;

    forward_unit u_fwd_a (
        .i_en(r_state != INIT), .i_rs(hz.Rs1E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
        .i_reg_write_m(hz.RegWriteM), .i_reg_write_w(hz.RegWriteW), .o_fwd(hz.ForwardAE)
    );
    forward_unit u_fwd_b (
        .i_en(r_state != INIT), .i_rs(hz.Rs2E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
        .i_reg_write_m(hz.RegWriteM), .i_reg_write_w(hz.RegWriteW), .o_fwd(hz.ForwardBE)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_cnt <= 4'(RESET_FLUSH_CYCLES);
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_init_cnt <= r_state == INIT ? r_init_cnt - 4'd1 : r_init_cnt;
            r_wait_cnt <= (w_next == MEMWAIT || w_next == HALT) ?
                          (r_wait_cnt == CNT_W'(MEM_TIMEOUT) ? r_wait_cnt : r_wait_cnt + 1'b1) : '0;
        end
    end

    // RUN and the MEMWAIT release cycle share one priority chain: busy > branch > load-use.
    always_comb begin
        w_next       = r_state;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FreezeEMW = 1'b0;
        case (r_state)
            INIT: begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
                w_next    = r_init_cnt == 4'd1 ? RUN : INIT;
            end
            RUN, MEMWAIT: begin
                if (w_mem_busy) begin
                    hz.StallF    = 1'b1;
                    hz.StallD    = 1'b1;
                    hz.FreezeEMW = 1'b1;
                    w_next = (r_state == MEMWAIT && r_wait_cnt == CNT_W'(MEM_TIMEOUT)) ? HALT : MEMWAIT;
                end else begin
                    hz.FlushD = hz.PCSrcE;
                    hz.FlushE = hz.PCSrcE || w_lw_stall;
                    hz.StallF = !hz.PCSrcE && w_lw_stall;
                    hz.StallD = !hz.PCSrcE && w_lw_stall;
                    w_next    = RUN;
                end
            end
            default: begin
                hz.StallF    = 1'b1;
                hz.StallD    = 1'b1;
                hz.FreezeEMW = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic w_branch_flush;
    assign w_branch_flush = (r_state == RUN || r_state == MEMWAIT) && !w_mem_busy && hz.PCSrcE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PerfStallCycles   <= '0;
            PerfFlushCount    <= '0;
            PerfMemWaitCycles <= '0;
        end else begin
            PerfStallCycles   <= PerfStallCycles + 32'(hz.StallF);
            PerfFlushCount    <= PerfFlushCount + 32'(w_branch_flush);
            PerfMemWaitCycles <= PerfMemWaitCycles + 32'(w_mem_busy);
        end
    end
`endif
endmodule
